inst_mem_fetch: RTL and testbench
=================================

INST_MEM_FETCH -- requirements
Module: inst_mem_fetch

Interface
REQ-001 Parameter DEPTH_BYTES, default 2048: byte capacity of the instruction store, power of two, at least WORD_BYTES.
REQ-002 Parameter WORD_BYTES, default 4: bytes per instruction word (power of two); DATA_W = 8*WORD_BYTES.
REQ-003 Parameter ADDR_W, default 32: fetch address width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 load_start  in  1  pulse; enter LOAD mode and rewind the load pointer.
REQ-007 ld_valid / ld_ready  in / out  1 / 1  loader byte handshake.
REQ-008 ld_byte  in  8  program byte; ld_last  in  1  marks the final byte of the image.
REQ-009 ld_count  out  $clog2(DEPTH_BYTES)+1  bytes stored since the last load_start; ld_ovf  out  1  sticky image-overflow flag.
REQ-010 req_valid / req_ready  in / out  1 / 1  fetch request handshake; req_addr  in  ADDR_W  byte address.
REQ-011 rsp_valid  out  1  one-cycle response pulse; rsp_instr  out  DATA_W  fetched word; rsp_err  out  2  [0]=misaligned, [1]=out-of-range.

Function
REQ-012 States: IDLE, LOAD, RUN (encoding from the package); the state after reset is IDLE.
REQ-013 IDLE->LOAD and RUN->LOAD on load_start; load_start in LOAD restarts the load (pointer 0, ld_ovf cleared, ld_count 0).
REQ-014 LOAD->RUN on an accepted byte with ld_last=1; there is no other exit from LOAD except rst.
REQ-015 ld_ready=1 exactly when state is LOAD; a byte is accepted when ld_valid && ld_ready.
REQ-016 An accepted byte is written to address ld_ptr; ld_ptr and ld_count then increment by 1.
REQ-017 Accepted bytes at ld_ptr >= DEPTH_BYTES: not written, no pointer wrap, ld_count saturates at DEPTH_BYTES, ld_ovf set; ld_ovf holds until load_start or rst.
REQ-018 req_ready = (state==RUN) && !load_start, combinational; requests in IDLE/LOAD are not accepted and produce no response.
REQ-019 An accepted request produces rsp_valid=1 exactly on the next clock cycle (1-cycle latency); there is no response backpressure, and a new request may be accepted every cycle.
REQ-020 Word assembly is big-endian: the byte at req_addr occupies rsp_instr[DATA_W-1:DATA_W-8], and the byte at req_addr+WORD_BYTES-1 occupies bits [7:0].
REQ-021 rsp_err[0]=1 when req_addr mod WORD_BYTES != 0.
REQ-022 rsp_err[1]=1 when req_addr+WORD_BYTES > DEPTH_BYTES, computed without ADDR_W overflow.
REQ-023 Both error bits may be set together; on any error rsp_instr = NOP (all zeros) and no array read is used.
REQ-024 rsp_instr and rsp_err hold their last values while rsp_valid=0.
REQ-025 A response for a request accepted in RUN is still delivered on the next cycle even if load_start arrives in that cycle.
REQ-026 Array contents persist across load_start and rst; bytes never loaded read as undefined.

Reset
REQ-027 On rst: state IDLE, ld_ptr 0, ld_count 0, ld_ovf 0, rsp_valid 0, rsp_instr 0, rsp_err 0.
REQ-028 rst takes priority over load_start and all handshakes in the same cycle.
REQ-029 rst mid-load or mid-fetch abandons the operation; no response follows rst.

Structure
REQ-030 Shared package imem_pkg holds: the state enum, the rsp_err bit indices, and the NOP constant.
REQ-031 One sub-module, imem_byte_ram: single write port (byte) and one WORD_BYTES-wide synchronous read port.

Verification
REQ-032 Load 00 43 08 20 00 43 08 22 00 62 08 20 (last on the 12th byte), then fetch 0, 4, 8 back-to-back -> 0x00430820, 0x00430822, 0x00620820 on consecutive cycles, rsp_err=00, ld_count=12.
REQ-033 With DEPTH_BYTES=16 in RUN: fetch 2 -> err=01; fetch 16 -> err=10; fetch 14 -> err=11; each with rsp_instr=0.
REQ-034 With DEPTH_BYTES=16: load 17 bytes, last on the 17th -> ld_ovf=1, ld_count=16, state RUN, bytes 0-15 intact.
REQ-035 After reset (IDLE), hold req_valid=1 -> req_ready=0, no rsp_valid; load_start in the same cycle as a RUN request -> request refused.
REQ-036 Assert rst after 5 loaded bytes -> IDLE, ld_ready=0, ld_count=0; a subsequent full reload and fetch returns the correct words.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory fetch block: the
// controller state encoding, the bit positions inside the response error
// field, and the byte used to build the NOP word returned on errors.
// ---------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  // The NOP word is this byte replicated across the instruction width.
  localparam logic [7:0] NOP_BYTE = 8'h00;

endpackage

// File: rtl/imem_byte_ram.sv
// ---------------------------------------------------------------------------
// imem_byte_ram
// Byte-organised instruction store with one byte-wide write port and one
// word-wide synchronous read port.  A read returns WORD_BYTES consecutive
// bytes starting at raddr_i, assembled big-endian (lowest address in the
// most significant byte).  The read register only changes when re_i is
// high, and the array itself has no reset.
//
// Ports:
//   clk      rising-edge clock
//   we_i     write enable for one byte
//   waddr_i  byte write address
//   wdata_i  byte to write
//   re_i     read enable (raddr_i must be word-aligned and in range)
//   raddr_i  byte read address of the first byte of the word
//   rdata_o  registered big-endian word
// ---------------------------------------------------------------------------
module imem_byte_ram #(
  parameter int DEPTH_BYTES = 2048,
  parameter int WORD_BYTES  = 4,
  parameter int AW          = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1,
  parameter int DATA_W      = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]        mem_q [DEPTH_BYTES];
  logic [DATA_W-1:0] rdata_q;

  // One byte written per cycle; the word read picks WORD_BYTES bytes
  // starting at the read address, first byte into the top lane.  The
  // controller never reads and writes in the same cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        rdata_q[DATA_W-1-8*i -: 8] <= mem_q[raddr_i + AW'(i)];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_fetch.sv
// ---------------------------------------------------------------------------
// inst_mem_fetch
// Instruction memory with a byte-stream loader and a single-cycle fetch
// port.  After load_start the block accepts program bytes one at a time
// into consecutive addresses; the byte flagged ld_last switches it to RUN,
// where word fetch requests are answered exactly one cycle later with a
// big-endian word and misalignment / out-of-range error flags.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   load_start             pulse: (re)enter LOAD and rewind the pointer
//   ld_valid/ld_ready      loader byte handshake (ld_ready high in LOAD)
//   ld_byte, ld_last       program byte, final-byte marker
//   ld_count, ld_ovf       bytes stored since load_start, sticky overflow
//   req_valid/req_ready    fetch request handshake (ready only in RUN)
//   req_addr               fetch byte address
//   rsp_valid              one-cycle response pulse
//   rsp_instr, rsp_err     fetched word (NOP on error), error flags
// ---------------------------------------------------------------------------
module inst_mem_fetch
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 2048,
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [7:0]                       ld_byte,
  input  logic                             ld_last,
  output logic [$clog2(DEPTH_BYTES):0]     ld_count,
  output logic                             ld_ovf,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_W-1:0]                req_addr,
  output logic                             rsp_valid,
  output logic [8*WORD_BYTES-1:0]          rsp_instr,
  output logic [1:0]                       rsp_err
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int CNT_W  = $clog2(DEPTH_BYTES) + 1;
  localparam int RAM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int OFF_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  state_e            state_q;
  logic [CNT_W-1:0]  ld_count_q;
  logic              ld_ovf_q;
  logic              rsp_valid_q;
  logic [1:0]        rsp_err_q;
  logic [DATA_W-1:0] instr_hold_q;

  logic              byte_acc;
  logic              byte_fits;
  logic              req_acc;
  logic              misalign;
  logic              out_of_range;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W:0]   req_end;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rsp_instr_d;

  assign ld_ready  = (state_q == ST_LOAD);
  assign req_ready = (state_q == ST_RUN) && !load_start;
  assign req_acc   = req_valid && req_ready;

  // A load_start arriving together with a byte restarts the image, so that
  // byte is dropped rather than stored at the old pointer.
  assign byte_acc  = ld_valid && ld_ready && !load_start;

  // The load pointer never wraps and the count saturates at the capacity,
  // so one register serves as both write pointer and byte count.
  assign byte_fits = ld_count_q < CNT_W'(DEPTH_BYTES);
  assign ram_we    = byte_acc && byte_fits;

  // Low offset bits of the address must be zero for a word fetch.
  generate
    if (WORD_BYTES > 1) begin : g_misalign
      assign misalign = |req_addr[OFF_W-1:0];
    end else begin : g_no_misalign
      assign misalign = 1'b0;
    end
  endgenerate

  // The end address is formed one bit wider so a request near the top of
  // the address space cannot wrap around and look in range.
  assign req_end      = {1'b0, req_addr} + (ADDR_W+1)'(WORD_BYTES);
  assign out_of_range = req_end > (ADDR_W+1)'(DEPTH_BYTES);

  // The array is only read for clean requests; errored responses use NOP.
  assign ram_re = req_acc && !misalign && !out_of_range;

  imem_byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WORD_BYTES  (WORD_BYTES),
    .AW          (RAM_AW),
    .DATA_W      (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ld_count_q[RAM_AW-1:0]),
    .wdata_i (ld_byte),
    .re_i    (ram_re),
    .raddr_i (req_addr[RAM_AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // During the response cycle the word comes straight from the RAM read
  // register (or NOP on error); otherwise the last delivered word is held.
  always_comb begin
    rsp_instr_d = instr_hold_q;
    if (rsp_valid_q) begin
      if (rsp_err_q != 2'b00) begin
        rsp_instr_d = {WORD_BYTES{NOP_BYTE}};
      end else begin
        rsp_instr_d = ram_rdata;
      end
    end
  end

  // Controller: load/run state, load pointer and overflow flag, and the
  // response pipeline stage.  A response accepted in RUN still completes
  // in the next cycle even if load_start moves the state to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ld_count_q   <= '0;
      ld_ovf_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 2'b00;
      instr_hold_q <= '0;
    end else begin
      rsp_valid_q <= req_acc;
      if (req_acc) begin
        rsp_err_q[ERR_MISALIGN] <= misalign;
        rsp_err_q[ERR_RANGE]    <= out_of_range;
      end
      if (rsp_valid_q) begin
        instr_hold_q <= rsp_instr_d;
      end

      if (load_start) begin
        state_q    <= ST_LOAD;
        ld_count_q <= '0;
        ld_ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_LOAD: begin
            if (byte_acc) begin
              if (byte_fits) begin
                ld_count_q <= ld_count_q + CNT_W'(1);
              end else begin
                ld_ovf_q <= 1'b1;
              end
              if (ld_last) begin
                state_q <= ST_RUN;
              end
            end
          end
          ST_RUN:  state_q <= ST_RUN;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ld_count  = ld_count_q;
  assign ld_ovf    = ld_ovf_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_instr = rsp_instr_d;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_fetch
// Directed bench for inst_mem_fetch built with a 16-byte store so that the
// range and overflow corners are cheap to reach.
// ---------------------------------------------------------------------------
module tb_inst_mem_fetch;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic [4:0]  ld_count;
  logic        ld_ovf;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] img [0:31];

  always #5 clk = ~clk;

  inst_mem_fetch #(
    .DEPTH_BYTES (DEPTH),
    .WORD_BYTES  (4),
    .ADDR_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_count   (ld_count),
    .ld_ovf     (ld_ovf),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_instr  (rsp_instr),
    .rsp_err    (rsp_err)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_prog_a();
    img[0] = 8'h00; img[1]  = 8'h43; img[2]  = 8'h08; img[3]  = 8'h20;
    img[4] = 8'h00; img[5]  = 8'h43; img[6]  = 8'h08; img[7]  = 8'h22;
    img[8] = 8'h00; img[9]  = 8'h62; img[10] = 8'h08; img[11] = 8'h20;
  endtask

  // Pulse load_start, then stream n bytes from img, flagging the last one.
  task automatic load_image(input int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Present one request for a single cycle; on return the response cycle is visible.
  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ld_ready: got %b expected 0", ld_ready); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    tests++; if (ld_count !== 5'd0) begin fails++; $display("[TB] FAIL reset_ld_count: got %0d expected 0", ld_count); end
    tests++; if (ld_ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_ld_ovf: got %b expected 0", ld_ovf); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (rsp_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_rsp_instr: got %h expected 00000000", rsp_instr); end
    tests++; if (rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL reset_rsp_err: got %b expected 00", rsp_err); end
  endtask

  task automatic test_load_fetch();
    set_prog_a();
    load_image(12);
    tests++; if (ld_count !== 5'd12) begin fails++; $display("[TB] FAIL load_count: got %0d expected 12", ld_count); end
    tests++; if (ld_ovf !== 1'b0) begin fails++; $display("[TB] FAIL load_ovf: got %b expected 0", ld_ovf); end
    tests++; if (ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL load_run_ld_ready: got %b expected 0", ld_ready); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL load_run_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    req_addr  = 32'd0;
    tick();
    req_addr  = 32'd4;
    tests++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00430820 || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL b2b_word0: got v=%b %h err=%b expected v=1 00430820 err=00", rsp_valid, rsp_instr, rsp_err); end
    tick();
    req_addr  = 32'd8;
    tests++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00430822 || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL b2b_word1: got v=%b %h err=%b expected v=1 00430822 err=00", rsp_valid, rsp_instr, rsp_err); end
    tick();
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00620820 || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL b2b_word2: got v=%b %h err=%b expected v=1 00620820 err=00", rsp_valid, rsp_instr, rsp_err); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || rsp_instr !== 32'h00620820) begin fails++; $display("[TB] FAIL b2b_hold: got v=%b %h expected v=0 00620820", rsp_valid, rsp_instr); end
  endtask

  task automatic test_errors();
    fetch(32'd2);
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b01 || rsp_instr !== 32'h0) begin fails++; $display("[TB] FAIL err_misalign: got v=%b err=%b %h expected v=1 err=01 00000000", rsp_valid, rsp_err, rsp_instr); end
    fetch(32'd16);
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || rsp_instr !== 32'h0) begin fails++; $display("[TB] FAIL err_range: got v=%b err=%b %h expected v=1 err=10 00000000", rsp_valid, rsp_err, rsp_instr); end
    fetch(32'd14);
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b11 || rsp_instr !== 32'h0) begin fails++; $display("[TB] FAIL err_both: got v=%b err=%b %h expected v=1 err=11 00000000", rsp_valid, rsp_err, rsp_instr); end
    fetch(32'hFFFF_FFFC);
    tests++; if (rsp_err !== 2'b10 || rsp_instr !== 32'h0) begin fails++; $display("[TB] FAIL err_top_addr: got err=%b %h expected err=10 00000000", rsp_err, rsp_instr); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || rsp_err !== 2'b10 || rsp_instr !== 32'h0) begin fails++; $display("[TB] FAIL err_hold: got v=%b err=%b %h expected v=0 err=10 00000000", rsp_valid, rsp_err, rsp_instr); end
    fetch(32'd4);
    tests++; if (rsp_err !== 2'b00 || rsp_instr !== 32'h00430822) begin fails++; $display("[TB] FAIL err_recover: got err=%b %h expected err=00 00430822", rsp_err, rsp_instr); end
  endtask

  task automatic test_load_start_during_rsp();
    req_valid = 1'b1;
    req_addr  = 32'd8;
    tick();
    req_valid  = 1'b0;
    load_start = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00620820) begin fails++; $display("[TB] FAIL ls_rsp_kept: got v=%b %h expected v=1 00620820", rsp_valid, rsp_instr); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL ls_req_ready: got %b expected 0", req_ready); end
    tick();
    load_start = 1'b0;
    tests++; if (ld_ready !== 1'b1 || rsp_valid !== 1'b0 || ld_count !== 5'd0) begin fails++; $display("[TB] FAIL ls_enter_load: got rdy=%b v=%b cnt=%0d expected rdy=1 v=0 cnt=0", ld_ready, rsp_valid, ld_count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) img[i] = 8'h10 + 8'(i);
    load_image(17);
    tests++; if (ld_ovf !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag: got %b expected 1", ld_ovf); end
    tests++; if (ld_count !== 5'd16) begin fails++; $display("[TB] FAIL ovf_count: got %0d expected 16", ld_count); end
    tests++; if (ld_ready !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("[TB] FAIL ovf_run: got ld_rdy=%b req_rdy=%b expected 0 1", ld_ready, req_ready); end
    fetch(32'd0);
    tests++; if (rsp_instr !== 32'h10111213 || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL ovf_word0: got %h err=%b expected 10111213 err=00", rsp_instr, rsp_err); end
    fetch(32'd12);
    tests++; if (rsp_instr !== 32'h1C1D1E1F || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL ovf_word3: got %h err=%b expected 1c1d1e1f err=00", rsp_instr, rsp_err); end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests++; if (ld_ovf !== 1'b0 || ld_count !== 5'd0 || ld_ready !== 1'b1) begin fails++; $display("[TB] FAIL ovf_clear: got ovf=%b cnt=%0d rdy=%b expected 0 0 1", ld_ovf, ld_count, ld_ready); end
  endtask

  task automatic test_idle_refuse();
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'd0;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL idle_req_ready: got %b expected 0", req_ready); end
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_no_rsp1: got %b expected 0", rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_no_rsp2: got %b expected 0", rsp_valid); end
    req_valid = 1'b0;
    set_prog_a();
    load_image(12);
    req_valid  = 1'b1;
    req_addr   = 32'd0;
    load_start = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL run_ls_req_ready: got %b expected 0", req_ready); end
    tick();
    req_valid  = 1'b0;
    load_start = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || ld_ready !== 1'b1) begin fails++; $display("[TB] FAIL run_ls_refused: got v=%b ld_rdy=%b expected v=0 ld_rdy=1", rsp_valid, ld_ready); end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 12; i++) img[i] = 8'hA0 + 8'(i);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_byte  = img[i];
      tick();
    end
    tests++; if (ld_count !== 5'd5) begin fails++; $display("[TB] FAIL midload_count: got %0d expected 5", ld_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    tests++; if (ld_ready !== 1'b0 || ld_count !== 5'd0 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL midload_reset: got rdy=%b cnt=%0d req_rdy=%b expected 0 0 0", ld_ready, ld_count, req_ready); end
    load_image(12);
    fetch(32'd0);
    tests++; if (rsp_instr !== 32'hA0A1A2A3 || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL reload_word0: got %h err=%b expected a0a1a2a3 err=00", rsp_instr, rsp_err); end
    fetch(32'd8);
    tests++; if (rsp_instr !== 32'hA8A9AAAB || rsp_err !== 2'b00) begin fails++; $display("[TB] FAIL reload_word2: got %h err=%b expected a8a9aaab err=00", rsp_instr, rsp_err); end
  endtask

  task automatic test_reset_midfetch();
    req_valid = 1'b1;
    req_addr  = 32'd4;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL midfetch_reset: got v=%b %h req_rdy=%b expected v=0 00000000 0", rsp_valid, rsp_instr, req_ready); end
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL midfetch_no_rsp: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_byte    = 8'h00;
    ld_last    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    test_reset();
    test_load_fetch();
    test_back_to_back();
    test_errors();
    test_load_start_during_rsp();
    test_overflow();
    test_idle_refuse();
    test_reset_midload();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
